// File: rtl/ram_copy_datapath.sv
// ram_copy_datapath
//   Address/data stage behind the Read/Write/Delay sequencer. It turns the
//   sequencer's one-hot Read and Write strobes into single-port RAM accesses
//   that copy Length words from SrcBase to DstBase. Each word takes one Read
//   followed by one Write. SlowRAM tells the sequencer that the current
//   destination word lies in the slow region, so the sequencer adds a Delay
//   cycle.
//   Optional feature macro: CHECKSUM_EN. When it is defined, the block adds a
//   Checksum output that holds the XOR of every word written.
module ram_copy_datapath #(
    parameter int              AW        = 8,
    parameter int              DW        = 8,
    parameter logic [AW-1:0]   SLOW_BASE = 8'hC0
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Read,
    input  logic          Write,
    input  logic          Start,
    input  logic [AW-1:0] SrcBase,
    input  logic [AW-1:0] DstBase,
    input  logic [AW-1:0] Length,
    input  logic [DW-1:0] RamRdData,
    output logic [AW-1:0] RamAddr,
    output logic          RamRdEn,
    output logic          RamWrEn,
    output logic [DW-1:0] RamWrData,
    output logic          SlowRAM,
    output logic          Busy,
    output logic          Done,
    output logic          Error
`ifdef CHECKSUM_EN
    ,
    output logic [DW-1:0] Checksum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;

    logic [AW-1:0] src_a_s;
    logic [AW-1:0] dst_a_s;
    logic [AW-1:0] idx_inc_s;
    logic          start_acc_s;
    logic          wr_fire_s;
    logic          rd_en_s;
    logic [AW-1:0] addr_s;

    // The addresses wrap modulo 2^AW because the sums are kept at AW bits.
    assign src_a_s     = src_q + idx_q;
    assign dst_a_s     = dst_q + idx_q;
    assign idx_inc_s   = idx_q + {{(AW-1){1'b0}}, 1'b1};
    assign start_acc_s = (state_q == ST_IDLE) && Start;
    // A write reaches the RAM only when a read for this word is outstanding.
    assign wr_fire_s   = (state_q == ST_ACTIVE) && Write && pend_q;

    // Next-state logic, copy bookkeeping and RAM read/address decode for each strobe
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        err_d   = err_q;
        rd_en_s = 1'b0;
        addr_s  = {AW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    src_d   = SrcBase;
                    dst_d   = DstBase;
                    len_d   = Length;
                    idx_d   = {AW{1'b0}};
                    pend_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = (Length == {AW{1'b0}}) ? ST_DONE : ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (Write) begin
                    // Write wins over a simultaneous Read. A write with no
                    // preceding read is a protocol error.
                    err_d = err_q | Read | ~pend_q;
                    if (pend_q) begin
                        addr_s = dst_a_s;
                        pend_d = 1'b0;
                        idx_d  = idx_inc_s;
                        if (idx_inc_s == len_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        pend_d = pend_q;
                    end
                end else if (Read) begin
                    // A second read before the write re-reads the word and flags an error.
                    rd_en_s = 1'b1;
                    addr_s  = src_a_s;
                    pend_d  = 1'b1;
                    err_d   = err_q | pend_q;
                end else begin
                    pend_d = pend_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and copy-context registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            src_q   <= {AW{1'b0}};
            dst_q   <= {AW{1'b0}};
            len_q   <= {AW{1'b0}};
            idx_q   <= {AW{1'b0}};
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign RamRdEn   = rd_en_s;
    assign RamWrEn   = wr_fire_s;
    assign RamAddr   = addr_s;
    assign RamWrData = wr_fire_s ? RamRdData : {DW{1'b0}};
    assign SlowRAM   = (state_q == ST_ACTIVE) && (dst_a_s >= SLOW_BASE);
    assign Busy      = (state_q == ST_ACTIVE);
    assign Done      = (state_q == ST_DONE);
    assign Error     = err_q;

`ifdef CHECKSUM_EN
    logic [DW-1:0] chk_d, chk_q;

    // Checksum folds in each word that is actually written. An accepted Start clears it.
    always_comb begin
        if (start_acc_s) begin
            chk_d = {DW{1'b0}};
        end else if (wr_fire_s) begin
            chk_d = chk_q ^ RamRdData;
        end else begin
            chk_d = chk_q;
        end
    end

    // Checksum register. It holds its value after Done until the next Start.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            chk_q <= {DW{1'b0}};
        end else begin
            chk_q <= chk_d;
        end
    end

    assign Checksum = chk_q;
`endif

endmodule

// File: tb/tb_ram_copy_datapath.sv
// Directed bench for ram_copy_datapath. The bench contains a RAM, and a
// word-level copy model predicts every cycle's outputs.
module tb_ram_copy_datapath;

    logic       Clock = 1'b0;
    logic       Reset, Read, Write, Start;
    logic [7:0] SrcBase, DstBase, Length, RamRdData, RamAddr, RamWrData;
    logic       RamRdEn, RamWrEn, SlowRAM, Busy, Done, Error;
`ifdef CHECKSUM_EN
    logic [7:0] Checksum;
`endif

    ram_copy_datapath dut (
        .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .Start(Start),
        .SrcBase(SrcBase), .DstBase(DstBase), .Length(Length), .RamRdData(RamRdData),
        .RamAddr(RamAddr), .RamRdEn(RamRdEn), .RamWrEn(RamWrEn), .RamWrData(RamWrData),
        .SlowRAM(SlowRAM), .Busy(Busy), .Done(Done), .Error(Error)
`ifdef CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Bench-side synchronous single-port RAM
    logic [7:0] mem [256];
    logic       init_all = 1'b0;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;

    always @(posedge Clock) begin
        if (init_all) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (RamWrEn) mem[RamAddr] <= RamWrData;
        if (RamRdEn) RamRdData <= mem[RamAddr];
    end

    // Word-level model: phase 0 idle, 1 copying, 2 done pulse
    int         phase = 0;
    logic [7:0] m_src = 8'h00, m_dst = 8'h00, m_len = 8'h00, m_words = 8'h00;
    logic       m_pend = 1'b0, m_err = 1'b0;
    logic [7:0] m_chk = 8'h00;
    logic [7:0] gold [256];

    logic       cmp_on = 1'b0;
    logic       e_rden, e_wren, e_slow, e_busy, e_done, e_err;
    logic [7:0] e_addr, e_wdata, e_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge Clock) begin
        if (cmp_on) begin
            chk("RamRdEn",   32'(RamRdEn),   32'(e_rden));
            chk("RamWrEn",   32'(RamWrEn),   32'(e_wren));
            chk("RamAddr",   32'(RamAddr),   32'(e_addr));
            chk("RamWrData", 32'(RamWrData), 32'(e_wdata));
            chk("SlowRAM",   32'(SlowRAM),   32'(e_slow));
            chk("Busy",      32'(Busy),      32'(e_busy));
            chk("Done",      32'(Done),      32'(e_done));
            chk("Error",     32'(Error),     32'(e_err));
`ifdef CHECKSUM_EN
            chk("Checksum",  32'(Checksum),  32'(e_chk));
`endif
        end
    end

    // Apply strobes for one cycle and compute that cycle's expected outputs.
    task automatic set_cyc(input logic r, input logic w, input logic s);
        logic [7:0] sa, da;
        Read = r; Write = w; Start = s;
        sa = m_src + m_words;
        da = m_dst + m_words;
        e_busy = (phase == 1);
        e_done = (phase == 2);
        e_err  = m_err;
        e_chk  = m_chk;
        e_rden = 1'b0; e_wren = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
        e_slow = (phase == 1) && (da >= 8'hC0);
        if (phase == 1) begin
            if (w) begin
                if (m_pend) begin
                    e_wren = 1'b1; e_addr = da; e_wdata = gold[sa];
                end
            end else if (r) begin
                e_rden = 1'b1; e_addr = sa;
            end
        end
    endtask

    // Advance one clock and update the model with what was applied.
    task automatic fin();
        logic [7:0] sa, da, data;
        @(posedge Clock);
        sa = m_src + m_words;
        da = m_dst + m_words;
        case (phase)
            0: if (Start) begin
                m_src = SrcBase; m_dst = DstBase; m_len = Length;
                m_words = 8'h00; m_pend = 1'b0; m_err = 1'b0; m_chk = 8'h00;
                phase = (Length == 8'h00) ? 2 : 1;
            end
            1: if (Write) begin
                if (Read) m_err = 1'b1;
                if (m_pend) begin
                    data = gold[sa];
                    gold[da] = data;
                    m_chk = m_chk ^ data;
                    m_words = m_words + 8'h01;
                    m_pend = 1'b0;
                    if (m_words == m_len) phase = 2;
                end else begin
                    m_err = 1'b1;
                end
            end else if (Read) begin
                if (m_pend) m_err = 1'b1;
                m_pend = 1'b1;
            end
            2: phase = 0;
            default: phase = 0;
        endcase
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic s);
        set_cyc(r, w, s);
        fin();
    endtask

    task automatic do_reset(input logic r);
        cmp_on = 1'b0;
        Reset = 1'b1; Read = r; Write = 1'b0; Start = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        phase = 0; m_src = 8'h00; m_dst = 8'h00; m_len = 8'h00; m_words = 8'h00;
        m_pend = 1'b0; m_err = 1'b0; m_chk = 8'h00;
        cmp_on = 1'b1;
    endtask

    // Sequencer-like copy: R, W, plus a Delay after each slow write.
    task automatic copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input logic poke);
        SrcBase = s; DstBase = d; Length = l;
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < int'(l); i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (poke && i == 1) begin
                SrcBase = 8'hEE; DstBase = 8'hEE; Length = 8'h01;
                drive(1'b0, 1'b0, 1'b1);
            end
            drive(1'b0, 1'b1, 1'b0);
            if (8'(int'(d) + i) >= 8'hC0) drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; Read = 1'b0; Write = 1'b0; Start = 1'b0;
        SrcBase = 8'h00; DstBase = 8'h00; Length = 8'h00;
        for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'hA5;
        init_all = 1'b1;
        do_reset(1'b0);
        init_all = 1'b0;

        // Reset state, with strobes in IDLE ignored
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);

        // T1: fast-region copy; a Start mid-copy must be ignored
        copy(8'h10, 8'h20, 8'd3, 1'b1);
        chk("t1_mem20", 32'(mem[8'h20]), 32'h0000_00B5);
        chk("t1_mem22", 32'(mem[8'h22]), 32'h0000_00B7);

        // T2: destination crosses into the slow region
        SrcBase = 8'h30; DstBase = 8'hBF; Length = 8'd2;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        set_cyc(1'b0, 1'b1, 1'b0); #1 chk("t2_slow_w1", 32'(SlowRAM), 32'h0); fin();
        drive(1'b1, 1'b0, 1'b0);
        set_cyc(1'b0, 1'b1, 1'b0); #1 chk("t2_slow_w2", 32'(SlowRAM), 32'h1); fin();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("t2_memC0", 32'(mem[8'hC0]), 32'h0000_0094);

        // T3: source address wraps, overlapping destination
        copy(8'hFE, 8'h01, 8'd4, 1'b0);
        chk("t3_mem01", 32'(mem[8'h01]), 32'h0000_005B);
        chk("t3_mem04", 32'(mem[8'h04]), 32'h0000_005B);

        // T4: zero-length copy; strobes during DONE and IDLE are ignored
        SrcBase = 8'h00; DstBase = 8'h00; Length = 8'd0;
        drive(1'b0, 1'b0, 1'b1);
        set_cyc(1'b1, 1'b0, 1'b0); #1 chk("t4_done", 32'(Done), 32'h1); fin();
        drive(1'b0, 1'b1, 1'b0);

        // T5: write without read, then reset mid-copy
        SrcBase = 8'h70; DstBase = 8'h80; Length = 8'd3;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        set_cyc(1'b0, 1'b0, 1'b0); #1 chk("t5_err", 32'(Error), 32'h1); fin();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        set_cyc(1'b0, 1'b0, 1'b0); #1 chk("t5_err_sticky", 32'(Error), 32'h1); fin();
        drive(1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("t5_mem80", 32'(mem[8'h80]), 32'h0000_00D5);
        chk("t5_mem81", 32'(mem[8'h81]), 32'h0000_0024);
        copy(8'h44, 8'hA0, 8'd2, 1'b0);

        // Re-read and Read+Write protocol errors
        SrcBase = 8'h40; DstBase = 8'h90; Length = 8'd2;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // T6: checksum words
        ld_en = 1'b1;
        ld_addr = 8'h50; ld_data = 8'hA5; gold[8'h50] = 8'hA5; drive(1'b0, 1'b0, 1'b0);
        ld_addr = 8'h51; ld_data = 8'h0F; gold[8'h51] = 8'h0F; drive(1'b0, 1'b0, 1'b0);
        ld_addr = 8'h52; ld_data = 8'hFF; gold[8'h52] = 8'hFF; drive(1'b0, 1'b0, 1'b0);
        ld_en = 1'b0;
        copy(8'h50, 8'h60, 8'd3, 1'b0);
        chk("t6_mem62", 32'(mem[8'h62]), 32'h0000_00FF);
`ifdef CHECKSUM_EN
        chk("t6_checksum", 32'(Checksum), 32'h0000_0055);
`endif

        // Whole-memory comparison against the model image
        cmp_on = 1'b0;
        for (int i = 0; i < 256; i++) chk("mem_image", 32'(mem[i]), 32'(gold[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
